// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the FSM state encoding, requester ids and the default data width.
package mem_arb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_arb2_sel.sv
// Two-way requester pick: fixed data-over-fetch, or round-robin
// against the last winner when RR is set.
module arb2_sel
  import mem_arb_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic    req_f_i,
  input  logic    req_d_i,
  input  req_id_t last_i,
  output logic    gnt_o,
  output req_id_t id_o
);

  logic both;
  logic d_only;

  assign both   = req_f_i & req_d_i;
  assign d_only = req_d_i & ~req_f_i;

  always_comb begin
    gnt_o = req_f_i | req_d_i;
    id_o  = FETCH;
    unique case (1'b1)
      both: begin
        if (RR && (last_i == DATA)) begin
          id_o = FETCH;
        end else begin
          id_o = DATA;
        end
      end
      d_only:  id_o = DATA;
      default: id_o = FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer shared by fetch and load/store ports.
// Define MEM_ARBITER_RR_EN for round-robin priority on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state_q, state_d;
  req_id_t         win_q, win_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            en_q, en_d;
  logic            mwe_q, mwe_d;
  logic [AW-1:0]   maddr_q, maddr_d;
  logic [XLEN-1:0] mwdata_q, mwdata_d;
  logic            iack_q, iack_d;
  logic            dack_q, dack_d;
  logic            ierr_q, ierr_d;
  logic            derr_q, derr_d;

  logic            gnt_any;
  req_id_t         gnt_id;
  req_id_t         last_q;
  logic            i_oor, d_oor;
  logic [XLEN-1:0] sel_addr;
  logic            sel_we;
  logic            sel_oor;
  logic            unused_ok;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
  req_id_t last_d;

  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && gnt_any) begin
      last_d = gnt_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= FETCH;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam bit RR_EN = 1'b0;
  assign last_q = FETCH;
`endif

  arb2_sel #(
    .RR(RR_EN)
  ) u_sel (
    .req_f_i(i_req),
    .req_d_i(d_req),
    .last_i (last_q),
    .gnt_o  (gnt_any),
    .id_o   (gnt_id)
  );

  // Anything above the word-index bits must be zero to hit the array.
  assign i_oor = |(i_addr >> (AW + 2));
  assign d_oor = |(d_addr >> (AW + 2));

  assign sel_addr = (gnt_id == DATA) ? d_addr : i_addr;
  assign sel_we   = (gnt_id == DATA) & d_we;
  assign sel_oor  = (gnt_id == DATA) ? d_oor : i_oor;

  assign unused_ok = ^sel_addr[1:0];

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    en_d     = 1'b0;
    mwe_d    = 1'b0;
    maddr_d  = '0;
    mwdata_d = '0;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    ierr_d   = 1'b0;
    derr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          win_d   = gnt_id;
          we_d    = sel_we;
          err_d   = sel_oor;
          en_d    = ~sel_oor;
          mwe_d   = sel_we & ~sel_oor;
          maddr_d = sel_addr[AW+1:2];
          if (sel_we && !sel_oor) begin
            mwdata_d = d_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        iack_d  = (win_q == FETCH);
        dack_d  = (win_q == DATA);
        ierr_d  = (win_q == FETCH) & err_q;
        derr_d  = (win_q == DATA) & err_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= FETCH;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      en_q     <= en_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      ierr_q   <= ierr_d;
      derr_q   <= derr_d;
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign i_ack     = iack_q;
  assign d_ack     = dack_q;
  assign i_err     = ierr_q;
  assign d_err     = derr_q;

  // Read data is the only unregistered output: memory answers in RESP.
  assign i_rdata = (iack_q && !err_q) ? mem_rdata : '0;
  assign d_rdata = (dack_q && !we_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases then random traffic checked
// against a timeline model of grants, acks and memory contents.
module tb_mem_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int XLEN  = 32;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  logic            i_err;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          last_ref;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          txn_no  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h0080_00EF;
    return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  // Environment memory: reloads its contents while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      mem_rdata <= tb_mem[mem_addr];
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic init_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    last_ref = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s txn=%0d observed=%h expected=%h",
             tag, txn_no, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(mem_en), 32'd0);
    chk({tag, "_we"},   32'(mem_we), 32'd0);
    chk({tag, "_iack"}, 32'(i_ack),  32'd0);
    chk({tag, "_dack"}, 32'(d_ack),  32'd0);
    chk({tag, "_ird"},  i_rdata,     32'd0);
    chk({tag, "_drd"},  d_rdata,     32'd0);
    chk({tag, "_ierr"}, 32'(i_err),  32'd0);
    chk({tag, "_derr"}, 32'(d_err),  32'd0);
  endtask

  // nf fetch accesses (2 = req left high over one ack), optional data access.
  task automatic run_txn(input int nf, input logic [31:0] fa,
                         input bit dv, input bit dwe,
                         input logic [31:0] da, input logic [31:0] dwd);
    bit          gd[4];
    bit          gerr[4];
    bit          gwe[4];
    logic [31:0] grd[4];
    int          gword[4];
    int          ng, fl, fdone, j, ph;
    bit          dl, pd;
    logic [31:0] a;
    bit          e_en, e_we, e_ia, e_da;
    txn_no++;
    ng = 0; fl = nf; dl = dv; fdone = 0;
    while ((fl > 0 || dl) && ng < 4) begin
      if (fl > 0 && dl) pd = RR ? (last_ref == 1'b0) : 1'b1;
      else pd = dl;
      a = pd ? da : fa;
      gd[ng]    = pd;
      gwe[ng]   = pd & dwe;
      gerr[ng]  = (a >= 32'(DEPTH * 4));
      gword[ng] = int'((a >> 2) % DEPTH);
      grd[ng]   = (gerr[ng] || gwe[ng]) ? 32'd0 : ref_mem[gword[ng]];
      if (gwe[ng] && !gerr[ng]) ref_mem[gword[ng]] = dwd;
      last_ref = pd;
      if (pd) dl = 1'b0;
      else fl--;
      ng++;
    end
    i_req = (nf > 0); i_addr = fa;
    d_req = dv; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int t = 0; t < 3 * ng; t++) begin
      j  = t / 3;
      ph = t % 3;
      @(negedge clk);
      e_en = (ph == 0) && !gerr[j];
      e_we = e_en && gwe[j];
      e_ia = (ph == 1) && !gd[j];
      e_da = (ph == 1) && gd[j];
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(gword[j]));
      if (e_we) chk("mem_wdata", mem_wdata, dwd);
      chk("i_ack", 32'(i_ack), 32'(e_ia));
      chk("d_ack", 32'(d_ack), 32'(e_da));
      chk("i_rdata", i_rdata, e_ia ? grd[j] : 32'd0);
      chk("d_rdata", d_rdata, e_da ? grd[j] : 32'd0);
      chk("i_err", 32'(i_err), 32'(e_ia && gerr[j]));
      chk("d_err", 32'(d_err), 32'(e_da && gerr[j]));
      if (e_ia) begin
        fdone++;
        if (fdone == nf) i_req = 1'b0;
      end
      if (e_da) d_req = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 5) == 0) begin
      a = $urandom | 32'h0000_0100;
    end else begin
      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int mode, nf;
    bit dv, dwe;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    init_ref();
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    run_txn(1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    run_txn(1, 32'h04, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("store_landed", tb_mem[4], 32'hDEADBEEF);
    run_txn(1, 32'h04, 1'b1, 1'b0, 32'h10, 32'h0);
    run_txn(0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    run_txn(0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);

    i_req = 1'b1; i_addr = 32'h08;
    @(negedge clk);
    chk("rst_pre_en", 32'(mem_en), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    chk("midrst_noack", 32'(i_ack), 32'd0);
    reset = 1'b0;
    init_ref();
    run_txn(1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);

    run_txn(2, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int k = 0; k < 60; k++) begin
      mode = $urandom_range(0, 3);
      nf   = (mode == 1) ? 0 : ((mode == 3) ? 2 : 1);
      dv   = (mode != 0) && ((mode != 3) || ($urandom_range(0, 1) == 1));
      dwe  = $urandom_range(0, 1) == 1;
      run_txn(nf, rnd_addr(), dv, dwe, rnd_addr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
